// File: rtl/uart_pkg.sv
// Types and constants shared across the UART blocks (RX, TX and the TX byte queue).
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } tx_fifo_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with an occupancy count. Head word is presented combinationally on dout.
// Storage is not cleared by reset.
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            din,
    output logic [DATA_W-1:0]            dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of the UART transmitter: buffers host writes and launches one byte at a time
// over the tx_en / tx_busy / tx_done handshake, abandoning a byte if the transmitter never goes busy.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W       = UART_DATA_W,
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         send_en,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         timeout_err,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         tx_en,
    input  logic                         tx_busy,
    input  logic                         tx_done
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

    // Handshake: tx_en is a one-cycle strobe with tx_data already stable; the transmitter answers
    // with tx_busy (accepted) and later a one-cycle tx_done; tx_data holds until the next pop.
    tx_fifo_state_t    state;
    logic [TW-1:0]     timer;
    logic [DATA_W-1:0] head;
    logic              pop;
    logic              push;

    // Pop looks only at the registered empty flag, so a write never bypasses straight to the launcher.
    assign pop  = (state == IDLE) && send_en && !empty;
    assign push = wr_en && (!full || pop);

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            tx_data     <= '0;
            tx_en       <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overflow    <= wr_en && full && !pop;
            timeout_err <= 1'b0;
            tx_en       <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data <= head;
                        tx_en   <= 1'b1;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A completion seen here wins over busy: a fast transmitter may finish
                    // without ever showing busy, and must not leave us waiting for a second done.
                    if (tx_done) begin
                        state <= IDLE;
                    end else if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TIMER_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
